clk_en_gen: RTL
===============

CLK_EN_GEN -- requirements
Module: clk_en_gen

Interface
REQ-001 Parameter DIV_W, default 26, width of divider register and counter.
REQ-002 Parameter DEFAULT_DIV, default 25_000_000, divide ratio after reset (0.5 s strobe period at 50 MHz Clk).
REQ-003 Clk  input  1  single system clock, 50 MHz nominal, all logic on rising edge.
REQ-004 Reset_n  input  1  reset, asynchronous, active-low.
REQ-005 run  input  1  level request to generate strobes, synchronous to Clk.
REQ-006 div_load  input  1  one-cycle request to load div_in into divider register.
REQ-007 div_in  input  DIV_W  new divide ratio.
REQ-008 cnt_clr  input  1  synchronous clear of en_cnt.
REQ-009 clk_en  output  1  registered one-cycle clock-enable strobe for the downstream LED/clock-gating stage.
REQ-010 gate_en  output  1  registered level, high while state is RUN or STOPPING, for a downstream clock-gate enable.
REQ-011 busy  output  1  registered, high whenever state is not IDLE.
REQ-012 en_cnt  output  16  number of strobes issued since reset or last clear.

Function
REQ-013 FSM states SHALL be IDLE, RUN, STOPPING; all outputs registered.
REQ-014 IDLE: cnt held at 0; run=1 sampled -> RUN next cycle with cnt=0.
REQ-015 RUN/STOPPING: cnt increments by 1 per cycle; when cnt==div_reg-1, cnt returns to 0 and clk_en is 1 in the following cycle only.
REQ-016 First strobe: run sampled high at edge E0 -> clk_en high after edge E0+div_reg+1; subsequent strobes every div_reg cycles exactly.
REQ-017 RUN with run=0 sampled -> STOPPING; cnt not disturbed.
REQ-018 STOPPING: counting continues until cnt==div_reg-1; at that edge state -> IDLE and final strobe is issued (clk_en=1, busy=0, gate_en=0 in the same cycle).
REQ-019 STOPPING with run=1 sampled -> RUN, cnt continues without restart; no strobe lost or duplicated.
REQ-020 Stop/restart SHALL never produce a strobe period shorter than div_reg cycles.
REQ-021 div_load honoured only in IDLE; ignored in RUN/STOPPING (div_reg unchanged).
REQ-022 div_in below 2 SHALL load as 2 (clamp); minimum strobe period 2 cycles.
REQ-023 en_cnt increments by 1 on each cycle clk_en=1; wraps 0xFFFF -> 0x0000.
REQ-024 cnt_clr=1 sets en_cnt to 0 next cycle; cnt_clr has priority over a simultaneous increment (strobe not counted).
REQ-025 Simultaneous div_load and run=1 in IDLE: new div_in used for the run being started.

Reset
REQ-026 Reset_n low SHALL immediately force state IDLE, cnt=0, clk_en=0, gate_en=0, busy=0, en_cnt=0, div_reg=DEFAULT_DIV, independent of Clk.
REQ-027 Reset asserted mid-RUN aborts without a final strobe; after release, block waits in IDLE for run.
REQ-028 First active edge after Reset_n rises behaves as ordinary IDLE edge.

Verification
REQ-029 Load div_in=4 in IDLE, run=1 at edge 0 held -> clk_en high after edges 5, 9, 13, ... ; en_cnt 1,2,3; gate_en/busy high from edge 1.
REQ-030 div=4 running, run=0 sampled when cnt=1 -> STOPPING, one more strobe 2 cycles later, then IDLE with busy=0 on the strobe cycle; no further strobes.
REQ-031 div=4, run dropped for 1 cycle then reasserted -> strobe spacing stays exactly 4 cycles, en_cnt continuous.
REQ-032 div_load with div_in=10 during RUN -> ignored, period stays 4; div_in=0 loaded in IDLE -> period 2.
REQ-033 en_cnt preset near wrap (run 65536 strobes at div=2) -> 0xFFFF -> 0x0000; cnt_clr coincident with strobe -> en_cnt=0, not 1.
REQ-034 Reset_n low for 7 ns asynchronously mid-RUN with Clk running -> all outputs 0 before next Clk edge, div_reg=DEFAULT_DIV, no strobe after release until run.

Source files
------------

// File: rtl/clk_en_gen.sv
// clk_en_gen: programmable clock-enable strobe generator with run/stop handshake.
// Revision 1.0
`default_nettype none

module clk_en_gen #(
  parameter int unsigned DIV_W       = 26,
  parameter int unsigned DEFAULT_DIV = 25_000_000
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             run,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_in,
  input  logic             cnt_clr,
  output logic             clk_en,
  output logic             gate_en,
  output logic             busy,
  output logic [15:0]      en_cnt
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_STOP = 2'd2;

  localparam logic [DIV_W-1:0] C_DEF_DIV = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] C_MIN_DIV = DIV_W'(2);
  localparam logic [DIV_W-1:0] C_ONE     = DIV_W'(1);

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             strobe_q;
  logic             clk_en_q;
  logic             gate_q;
  logic             busy_q;
  logic [15:0]      en_cnt_q, en_cnt_d;

  logic             wrap_w;
  logic [DIV_W-1:0] cnt_inc_w;

  assign wrap_w    = (state_q != S_IDLE) && (cnt_q == (div_q - C_ONE));
  assign cnt_inc_w = wrap_w ? '0 : (cnt_q + C_ONE);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (div_load) begin
          div_d = (div_in < C_MIN_DIV) ? C_MIN_DIV : div_in;
        end
        if (run) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_inc_w;
        if (!run) begin
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        cnt_d = cnt_inc_w;
        // Re-requesting run keeps the period running so no strobe is lost.
        if (run) begin
          state_d = S_RUN;
        end else if (wrap_w) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    en_cnt_d = en_cnt_q;
    if (cnt_clr) begin
      en_cnt_d = '0;
    end else if (strobe_q) begin
      en_cnt_d = en_cnt_q + 16'd1;
    end
  end

  // Status outputs lag the FSM by one cycle, aligning them with the strobe
  // so the final strobe coincides with busy/gate_en dropping.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      div_q    <= C_DEF_DIV;
      strobe_q <= 1'b0;
      clk_en_q <= 1'b0;
      gate_q   <= 1'b0;
      busy_q   <= 1'b0;
      en_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      strobe_q <= wrap_w;
      clk_en_q <= strobe_q;
      gate_q   <= (state_q == S_RUN) || (state_q == S_STOP);
      busy_q   <= (state_q != S_IDLE);
      en_cnt_q <= en_cnt_d;
    end
  end

  assign clk_en  = clk_en_q;
  assign gate_en = gate_q;
  assign busy    = busy_q;
  assign en_cnt  = en_cnt_q;

endmodule

`default_nettype wire
